spi_master_gen: RTL and testbench

Parametrised second-generation SPI master for the payload SoC peripheral bus. It generalises the fixed 8-bit master to a configurable word width, a runtime-selectable mode (CPOL/CPHA, MSB/LSB first), an internal programmable SCLK divider instead of an external divided clock, and up to NUM_CS chip selects with automatic setup, hold and gap timing. A start/done handshake lets the bus-side register block launch one word per transfer.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_clk_div.sv | 41 ++++
 rtl/spi_master_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_master_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and helpers for the parametrised SPI master.
//                State encoding, latched transfer mode, edge-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // Per-transfer mode, captured when a start is accepted
    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    // Width of a counter spanning the 2*data_w SCLK edges of one word
    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clk_div
//  Description : SCLK half-period tick generator. The counter runs 0..div and
//                tick is high in the cycle the count equals div, after which
//                the count restarts. div = 0 gives a tick every cycle.
//  Ports       : clk, reset (sync, active high), clear (hold count at 0),
//                div (half-period minus one), tick (half-period boundary)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt_q;
    logic [DIV_W-1:0] w_cnt_d;

    always_comb begin
        tick    = !clear && (r_cnt_q == div);
        w_cnt_d = r_cnt_q + DIV_W'(1);
        if (clear || tick) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_gen
//  Description : Parametrised SPI master. One word per start/done handshake,
//                runtime CPOL/CPHA/bit-order, internal SCLK divider and
//                NUM_CS chip selects with setup, hold and inter-word gap.
//  Ports       : clk, reset (sync, active high)
//                start, cpol, cpha, lsb_first, cs_sel, div, tx_data - request
//                miso - serial in; sclk, mosi, cs_n - serial bus
//                busy, done, rx_data - status and received word
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  NUM_CS = 4,
    parameter int  DIV_W  = 8,
    parameter int  CS_GAP = 2,
    localparam int c_CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [c_CS_W-1:0] cs_sel,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int c_EDGE_W = edge_cnt_w(DATA_W);
    // Gap counter runs 0..CS_GAP-1
    localparam int c_GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2 * DATA_W - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(CS_GAP - 1);

    spi_state_e          r_state_q,   w_state_d;
    spi_mode_t           r_mode_q,    w_mode_d;
    logic [DIV_W-1:0]    r_div_q,     w_div_d;
    logic [DATA_W-1:0]   r_tx_q,      w_tx_d;
    logic [DATA_W-1:0]   r_rx_sh_q,   w_rx_sh_d;
    logic [c_EDGE_W-1:0] r_edge_q,    w_edge_d;
    logic [c_GAP_W-1:0]  r_gap_q,     w_gap_d;
    logic                r_sclk_q,    w_sclk_d;
    logic                r_mosi_q,    w_mosi_d;
    logic [NUM_CS-1:0]   r_cs_n_q,    w_cs_n_d;
    logic                r_busy_q,    w_busy_d;
    logic                r_done_q,    w_done_d;
    logic [DATA_W-1:0]   r_rx_data_q, w_rx_data_d;

    logic                w_tick;
    logic                w_div_clear;
    logic [NUM_CS-1:0]   w_cs_dec;
    logic [DATA_W-1:0]   w_tx_shift;
    logic [DATA_W-1:0]   w_rx_shift;
    logic                w_first_in;
    logic                w_first_q;
    logic                w_first_next;

    // Divider only runs while the bus is being clocked or timed by half-periods
    assign w_div_clear = (r_state_q == ST_IDLE) || (r_state_q == ST_GAP);

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .clear (w_div_clear),
        .div   (r_div_q),
        .tick  (w_tick)
    );

    // The outgoing bit always sits at the end the register shifts towards
    assign w_tx_shift   = r_mode_q.lsb_first ? {1'b0, r_tx_q[DATA_W-1:1]}
                                             : {r_tx_q[DATA_W-2:0], 1'b0};
    assign w_first_q    = r_mode_q.lsb_first ? r_tx_q[0] : r_tx_q[DATA_W-1];
    assign w_first_next = r_mode_q.lsb_first ? w_tx_shift[0] : w_tx_shift[DATA_W-1];
    assign w_first_in   = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    assign w_rx_shift   = r_mode_q.lsb_first ? {miso, r_rx_sh_q[DATA_W-1:1]}
                                             : {r_rx_sh_q[DATA_W-2:0], miso};

    // Out-of-range selections match no index and leave every cs_n high
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == c_CS_W'(i)) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_mode_d    = r_mode_q;
        w_div_d     = r_div_q;
        w_tx_d      = r_tx_q;
        w_rx_sh_d   = r_rx_sh_q;
        w_edge_d    = r_edge_q;
        w_gap_d     = r_gap_q;
        w_sclk_d    = r_sclk_q;
        w_mosi_d    = r_mosi_q;
        w_cs_n_d    = r_cs_n_q;
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;
        w_rx_data_d = r_rx_data_q;

        case (r_state_q)
            ST_IDLE: begin
                // Track cpol so the idle level is settled before cs asserts
                w_sclk_d = cpol;
                w_mosi_d = 1'b0;
                w_cs_n_d = '1;
                w_busy_d = 1'b0;
                if (start) begin
                    w_state_d          = ST_SETUP;
                    w_mode_d.cpol      = cpol;
                    w_mode_d.cpha      = cpha;
                    w_mode_d.lsb_first = lsb_first;
                    w_div_d            = div;
                    w_tx_d             = tx_data;
                    w_rx_sh_d          = '0;
                    w_edge_d           = '0;
                    w_gap_d            = '0;
                    w_mosi_d           = w_first_in;
                    w_cs_n_d           = w_cs_dec;
                    w_busy_d           = 1'b1;
                end
            end

            ST_SETUP: begin
                if (w_tick) begin
                    w_state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (w_tick) begin
                    w_sclk_d = !r_sclk_q;
                    w_edge_d = r_edge_q + c_EDGE_W'(1);
                    if (!r_edge_q[0]) begin
                        // Leading edge
                        if (!r_mode_q.cpha) begin
                            w_rx_sh_d = w_rx_shift;
                        end else begin
                            w_mosi_d = w_first_q;
                            w_tx_d   = w_tx_shift;
                        end
                    end else begin
                        // Trailing edge
                        if (r_mode_q.cpha) begin
                            w_rx_sh_d = w_rx_shift;
                        end else if (r_edge_q != c_LAST_EDGE) begin
                            w_tx_d   = w_tx_shift;
                            w_mosi_d = w_first_next;
                        end
                    end
                    if (r_edge_q == c_LAST_EDGE) begin
                        w_mosi_d  = 1'b0;
                        w_state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                w_sclk_d = r_mode_q.cpol;
                if (w_tick) begin
                    w_cs_n_d  = '1;
                    w_gap_d   = '0;
                    w_state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                if (r_gap_q == c_GAP_LAST) begin
                    w_state_d   = ST_IDLE;
                    w_done_d    = 1'b1;
                    w_busy_d    = 1'b0;
                    w_rx_data_d = r_rx_sh_q;
                end else begin
                    w_gap_d = r_gap_q + c_GAP_W'(1);
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= ST_IDLE;
            r_mode_q    <= '0;
            r_div_q     <= '0;
            r_tx_q      <= '0;
            r_rx_sh_q   <= '0;
            r_edge_q    <= '0;
            r_gap_q     <= '0;
            r_sclk_q    <= 1'b0;
            r_mosi_q    <= 1'b0;
            r_cs_n_q    <= '1;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_rx_data_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_mode_q    <= w_mode_d;
            r_div_q     <= w_div_d;
            r_tx_q      <= w_tx_d;
            r_rx_sh_q   <= w_rx_sh_d;
            r_edge_q    <= w_edge_d;
            r_gap_q     <= w_gap_d;
            r_sclk_q    <= w_sclk_d;
            r_mosi_q    <= w_mosi_d;
            r_cs_n_q    <= w_cs_n_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_rx_data_q <= w_rx_data_d;
        end
    end

    assign sclk    = r_sclk_q;
    assign mosi    = r_mosi_q;
    assign cs_n    = r_cs_n_q;
    assign busy    = r_busy_q;
    assign done    = r_done_q;
    assign rx_data = r_rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_gen
//  Description : Directed self-checking bench for spi_master_gen. Three
//                instances: A (8-bit, 4 CS), B (16-bit, 4 CS), C (8-bit,
//                5 CS so that cs_sel=5 is out of range).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       cpol, cpha, lsb_first;
    logic [7:0] div;
    logic       loop_en;
    logic       miso_model;

    logic       a_start, a_sclk, a_mosi, a_busy, a_done, a_miso;
    logic [1:0] a_cs_sel;
    logic [7:0] a_tx, a_rx;
    logic [3:0] a_cs_n;

    logic        b_start, b_sclk, b_mosi, b_busy, b_done, b_miso;
    logic [1:0]  b_cs_sel;
    logic [15:0] b_tx, b_rx;
    logic [3:0]  b_cs_n;

    logic       c_start, c_sclk, c_mosi, c_busy, c_done, c_miso;
    logic [2:0] c_cs_sel;
    logic [7:0] c_tx, c_rx;
    logic [4:0] c_cs_n;

    assign a_miso = loop_en ? a_mosi : miso_model;
    assign b_miso = loop_en ? b_mosi : miso_model;
    assign c_miso = loop_en ? c_mosi : miso_model;

    spi_master_gen #(.DATA_W(8), .NUM_CS(4), .DIV_W(8), .CS_GAP(2)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_sel(a_cs_sel), .div(div), .tx_data(a_tx),
        .miso(a_miso), .sclk(a_sclk), .mosi(a_mosi), .cs_n(a_cs_n),
        .busy(a_busy), .done(a_done), .rx_data(a_rx)
    );

    spi_master_gen #(.DATA_W(16), .NUM_CS(4), .DIV_W(8), .CS_GAP(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_sel(b_cs_sel), .div(div), .tx_data(b_tx),
        .miso(b_miso), .sclk(b_sclk), .mosi(b_mosi), .cs_n(b_cs_n),
        .busy(b_busy), .done(b_done), .rx_data(b_rx)
    );

    spi_master_gen #(.DATA_W(8), .NUM_CS(5), .DIV_W(8), .CS_GAP(2)) u_dut_c (
        .clk(clk), .reset(reset), .start(c_start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_sel(c_cs_sel), .div(div), .tx_data(c_tx),
        .miso(c_miso), .sclk(c_sclk), .mosi(c_mosi), .cs_n(c_cs_n),
        .busy(c_busy), .done(c_done), .rx_data(c_rx)
    );

    // View of the instance under test, chip selects padded high to 8 bits
    int          sel;
    logic        w_sclk, w_mosi, w_busy, w_done;
    logic [7:0]  w_cs8;
    logic [15:0] w_rx;

    always_comb begin
        w_sclk = a_sclk; w_mosi = a_mosi; w_busy = a_busy; w_done = a_done;
        w_cs8  = {4'hF, a_cs_n};
        w_rx   = {8'h00, a_rx};
        if (sel == 1) begin
            w_sclk = b_sclk; w_mosi = b_mosi; w_busy = b_busy; w_done = b_done;
            w_cs8  = {4'hF, b_cs_n};
            w_rx   = b_rx;
        end else if (sel == 2) begin
            w_sclk = c_sclk; w_mosi = c_mosi; w_busy = c_busy; w_done = c_done;
            w_cs8  = {3'h7, c_cs_n};
            w_rx   = {8'h00, c_rx};
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Results of the last run_xfer
    int          m_done, m_cs_low, m_edges, m_first, m_tail;
    logic [7:0]  m_mask, m_cs_first;
    logic [31:0] m_seq;
    logic [15:0] m_rx;
    logic        m_busy1, m_aborted;

    // Launch one word on instance s and observe it cycle by cycle from t+1.
    // hold keeps start high; abort_e >= 0 returns right after edge abort_e.
    task automatic run_xfer(input int s, input logic [15:0] tx, input int cs,
                            input int dw, input logic [15:0] mword,
                            input bit hold, input int abort_e);
        int   mi, e, idx;
        logic prev_sclk, prev_mosi;
        sel = s;
        case (s)
            0:       begin a_tx = tx[7:0]; a_cs_sel = cs[1:0]; a_start = 1'b1; end
            1:       begin b_tx = tx;      b_cs_sel = cs[1:0]; b_start = 1'b1; end
            default: begin c_tx = tx[7:0]; c_cs_sel = cs[2:0]; c_start = 1'b1; end
        endcase
        mi = 0;
        if (!cpha) begin
            idx = lsb_first ? 0 : dw - 1;
            miso_model = mword[idx];
            mi = 1;
        end
        m_done = -1; m_cs_low = 0; m_edges = 0; m_first = -1; m_tail = 0;
        m_mask = '0; m_seq = '0; m_rx = '0; m_aborted = 1'b0;
        m_busy1 = 1'b0; m_cs_first = '0;
        prev_sclk = w_sclk;
        prev_mosi = w_mosi;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                m_busy1    = w_busy;
                m_cs_first = w_cs8;
                if (!hold) begin a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; end
            end
            if (w_cs8 != 8'hFF) begin
                m_cs_low++;
                m_mask = m_mask | ~w_cs8;
                m_tail = 0;
            end else begin
                m_tail++;
            end
            if (w_sclk != prev_sclk) begin
                e = m_edges;
                m_edges++;
                if (m_first < 0) m_first = k;
                // What the slave saw on mosi at the sampling edge
                if (e[0] == cpha) m_seq = {m_seq[30:0], prev_mosi};
                // Slave launches on the opposite edge to the master's sample
                if (e[0] != cpha && mi < dw) begin
                    idx = lsb_first ? mi : dw - 1 - mi;
                    miso_model = mword[idx];
                    mi++;
                end
                if (e == abort_e) begin
                    m_aborted = 1'b1;
                    return;
                end
            end
            prev_sclk = w_sclk;
            prev_mosi = w_mosi;
            if (w_done) begin
                m_done = k;
                m_rx   = w_rx;
                break;
            end
        end
    endtask

    logic [7:0] b2b_tx [3];
    int         n_done;

    initial begin
        b2b_tx = '{8'h12, 8'h34, 8'hC3};
        reset = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = 8'd0;
        loop_en = 1'b1; miso_model = 1'b0; sel = 0;
        a_start = 1'b0; a_cs_sel = '0; a_tx = '0;
        b_start = 1'b0; b_cs_sel = '0; b_tx = '0;
        c_start = 1'b0; c_cs_sel = '0; c_tx = '0;

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_sclk", 32'(w_sclk), 32'd0);
        check("rst_mosi", 32'(w_mosi), 32'd0);
        check("rst_cs_n", 32'(w_cs8), 32'hFF);
        check("rst_busy", 32'(w_busy), 32'd0);
        check("rst_done", 32'(w_done), 32'd0);
        check("rst_rx", 32'(w_rx), 32'd0);
        check("rst_cs_n_c", 32'(c_cs_n), 32'h1F);
        reset = 1'b0;

        // Mode 0, div=1, MSB first, loopback 0xA5 on cs 0
        div = 8'd1;
        repeat (2) @(posedge clk); #1;
        run_xfer(0, 16'h00A5, 0, 8, 16'h0, 1'b0, -1);
        check("m0_busy_t1", 32'(m_busy1), 32'd1);
        check("m0_cs_t1", 32'(m_cs_first), 32'hFE);
        check("m0_cs_low_cycles", 32'(m_cs_low), 32'd36);
        check("m0_cs_mask", 32'(m_mask), 32'h01);
        check("m0_first_edge", 32'(m_first), 32'd5);
        check("m0_edges", 32'(m_edges), 32'd16);
        check("m0_mosi_seq", 32'(m_seq[7:0]), 32'hA5);
        check("m0_done_cycle", 32'(m_done), 32'd39);
        check("m0_rx", 32'(m_rx), 32'hA5);
        check("m0_busy_at_done", 32'(w_busy), 32'd0);
        @(posedge clk); #1;
        check("m0_done_pulse", 32'(w_done), 32'd0);

        // Mode 3, LSB first, div=2, slave model sends 0x81
        cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1; div = 8'd2; loop_en = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("m3_idle_sclk", 32'(w_sclk), 32'd1);
        run_xfer(0, 16'h003C, 3, 8, 16'h0081, 1'b0, -1);
        check("m3_cs_t1", 32'(m_cs_first), 32'hF7);
        check("m3_mosi_seq", 32'(m_seq[7:0]), 32'b0011_1100);
        check("m3_edges", 32'(m_edges), 32'd16);
        check("m3_done_cycle", 32'(m_done), 32'd57);
        check("m3_rx", 32'(m_rx), 32'h81);
        check("m3_sclk_at_done", 32'(w_sclk), 32'd1);

        // 16-bit word, div=0, cs 2, loopback
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = 8'd0; loop_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        run_xfer(1, 16'hBEEF, 2, 16, 16'h0, 1'b0, -1);
        check("w16_cs_mask", 32'(m_mask), 32'h04);
        check("w16_edges", 32'(m_edges), 32'd32);
        check("w16_mosi_seq", 32'(m_seq[15:0]), 32'hBEEF);
        check("w16_done_cycle", 32'(m_done), 32'd37);
        check("w16_rx", 32'(m_rx), 32'hBEEF);

        // Out-of-range chip select on the 5-CS instance
        div = 8'd1;
        repeat (2) @(posedge clk); #1;
        run_xfer(2, 16'h005A, 5, 8, 16'h0, 1'b0, -1);
        check("oor_cs_mask", 32'(m_mask), 32'h00);
        check("oor_edges", 32'(m_edges), 32'd16);
        check("oor_done_cycle", 32'(m_done), 32'd39);
        check("oor_rx", 32'(m_rx), 32'h5A);

        // start held high for three back-to-back words on cs 1
        repeat (2) @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            run_xfer(0, {8'h00, b2b_tx[j]}, 1, 8, 16'h0, 1'b1, -1);
            check($sformatf("b2b%0d_busy_t1", j), 32'(m_busy1), 32'd1);
            check($sformatf("b2b%0d_cs_t1", j), 32'(m_cs_first), 32'hFD);
            check($sformatf("b2b%0d_done_cycle", j), 32'(m_done), 32'd39);
            check($sformatf("b2b%0d_cs_high_tail", j), 32'(m_tail), 32'd3);
            check($sformatf("b2b%0d_rx", j), 32'(m_rx), 32'(b2b_tx[j]));
        end
        a_start = 1'b0;
        @(posedge clk); #1;
        check("b2b_no_extra_accept", 32'(w_busy), 32'd0);

        // Reset at edge 5 of a mode-3 transfer
        cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b0; div = 8'd1; loop_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        run_xfer(0, 16'h00F0, 1, 8, 16'h0, 1'b0, 5);
        check("rst5_reached_edge", 32'(m_aborted), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst5_cs_n", 32'(w_cs8), 32'hFF);
        check("rst5_sclk", 32'(w_sclk), 32'd0);
        check("rst5_busy", 32'(w_busy), 32'd0);
        check("rst5_rx", 32'(w_rx), 32'd0);
        check("rst5_mosi", 32'(w_mosi), 32'd0);
        reset = 1'b0;
        n_done = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (w_done) n_done++;
        end
        check("rst5_no_done", 32'(n_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
